// File: rtl/hilo_muldiv_sequencer_pkg.sv
// Shared types and funct codes for the HI/LO multiply/divide sequencer.
package hilo_muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2,
    SIGN_FIX = 2'd3
  } MulDivState;

  // HI/LO funct codes, same values as the ALU funct table
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // 0x18..0x1B: the four iterative ops
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/hilo_muldiv_sequencer_muldiv_iter_core.sv
// Datapath for the iterative multiply/divide: {hi,lo} accumulator plus the
// second operand. One shift-add (multiply) or restore step (divide) per step.
// Multiply: lo starts as the multiplier and is shifted out as the product's
//   low half shifts in; hi collects the upper half.
// Divide: lo starts as the dividend and fills with quotient bits; hi is the
//   partial remainder.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;

  // Load operands or advance one iteration
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    if (load) begin
      hi_d = '0;
      lo_d = load_a;
      b_d  = load_b;
    end else if (step) begin
      if (is_div) begin
        // borrow out of the trial subtract means restore
        if (div_diff[WIDTH]) begin
          hi_d = div_trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end else begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO unit sequencer: owns HI/LO, serves MFHI/MFLO/MTHI/MTLO, and runs
// MULT/MULTU/DIV/DIVU one bit per cycle through muldiv_iter_core.
// Optional: define HILO_DIVZERO_FLAG_EN to add the divByZero output, high for
// the SIGN_FIX cycle of a zero-divisor DIV/DIVU.
module hilo_muldiv_sequencer
  import hilo_muldiv_sequencer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             opValid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  output logic             opReady,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] readData
`ifdef HILO_DIVZERO_FLAG_EN
  ,
  output logic             divByZero
`endif
);

  MulDivState       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;   // negate product / quotient
  logic             neg_hi_q, neg_hi_d;   // negate remainder
  logic             dz_q, dz_d;           // zero-divisor shortcut in flight

  logic             accept, signed_op, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign opReady   = (state_q == IDLE) && !flush;
  assign accept    = opValid && opReady;
  assign stall     = opValid && !opReady;
  assign busy      = (state_q != IDLE);
  assign signed_op = (funct == FN_MULT) || (funct == FN_DIV);
  assign sign_a    = signed_op && operandA[WIDTH-1];
  assign sign_b    = signed_op && operandB[WIDTH-1];
  // |-2^(W-1)| wraps back to 2^(W-1), which is the right unsigned magnitude
  assign abs_a     = sign_a ? -operandA : operandA;
  assign abs_b     = sign_b ? -operandB : operandB;
  assign div_zero  = (operandB == '0);
  assign prod_fix  = neg_lo_q ? -{core_hi, core_lo} : {core_hi, core_lo};

`ifdef HILO_DIVZERO_FLAG_EN
  assign divByZero = (state_q == SIGN_FIX) && dz_q;
`endif

  // Read port: only meaningful in the handshake cycle of MFHI/MFLO
  always_comb begin
    readData = '0;
    if (accept && funct == FN_MFHI) readData = hi_q;
    if (accept && funct == FN_MFLO) readData = lo_q;
  end

  // Zero-divisor ops park the raw dividend in the core so SIGN_FIX can copy it to HI
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (accept && is_muldiv(funct)),
    .step   ((state_q == MUL_ITER) || (state_q == DIV_ITER)),
    .is_div (is_div_q),
    .load_a ((is_muldiv(funct) && funct[1] && div_zero) ? operandA : abs_a),
    .load_b (abs_b),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Next-state, counter, sign latches and HI/LO writes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (funct)
            FN_MTHI: hi_d = operandA;
            FN_MTLO: lo_d = operandA;
            FN_MULT, FN_MULTU: begin
              state_d  = MUL_ITER;
              cnt_d    = CNT_W'(WIDTH);
              is_div_d = 1'b0;
              neg_lo_d = sign_a ^ sign_b;
              neg_hi_d = 1'b0;
              dz_d     = 1'b0;
            end
            FN_DIV, FN_DIVU: begin
              is_div_d = 1'b1;
              if (div_zero) begin
                state_d  = SIGN_FIX;
                cnt_d    = '0;
                neg_lo_d = 1'b0;
                neg_hi_d = 1'b0;
                dz_d     = 1'b1;
              end else begin
                state_d  = DIV_ITER;
                cnt_d    = CNT_W'(WIDTH);
                neg_lo_d = sign_a ^ sign_b;
                neg_hi_d = sign_a;
                dz_d     = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      MUL_ITER, DIV_ITER: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = SIGN_FIX;
        end
      end
      SIGN_FIX: begin
        state_d = IDLE;
        dz_d    = 1'b0;
        // a flush here discards the result
        if (!flush) begin
          if (dz_q) begin
            hi_d = core_lo;
            lo_d = '1;
          end else if (is_div_q) begin
            lo_d = neg_lo_q ? -core_lo : core_lo;
            hi_d = neg_hi_q ? -core_hi : core_hi;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
    end
  end

endmodule
